// File: rtl/ledr_pkg.sv
// Shared types and constants for the LEDR pattern decoder: index type, FSM states, pattern table.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ledr_pkg;

    typedef logic [4:0] ledr_idx_t;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        FAULT  = 2'd2
    } dec_state_t;

    localparam ledr_idx_t IDX_LOOP_START = 5'd11;
    localparam ledr_idx_t IDX_LAST       = 5'd16;

    localparam logic [9:0] LEDR_0 = 10'h000;

    // Patterns in sequence order: a fill ramp 0..10, then the repeating effect loop 11..16.
    localparam logic [9:0] LEDR_PATTERN [0:16] = '{
        10'h000, 10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F,
        10'h03F, 10'h07F, 10'h0FF, 10'h1FF, 10'h3FF,
        10'h2AA, 10'h155, 10'h3E0, 10'h01F, 10'h201, 10'h3FF
    };

    // Out-of-range indices never occur in operation; map them to LEDR_0 so the lookup is total.
    function automatic logic [9:0] pattern_of(input ledr_idx_t i);
        logic [9:0] p;
        p = LEDR_0;
        if (i <= IDX_LAST) begin
            p = LEDR_PATTERN[i];
        end
        return p;
    endfunction

    // The effect loop wraps from its last entry back to its first; the ramp is never re-entered.
    function automatic ledr_idx_t succ_of(input ledr_idx_t i);
        ledr_idx_t s;
        s = ledr_idx_t'(i + 5'd1);
        if (i == IDX_LAST) begin
            s = IDX_LOOP_START;
        end
        return s;
    endfunction

endpackage

// File: rtl/ledr_pattern_lut.sv
// Maps a sequence index to its own pattern and to the pattern of its legal successor.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow idx continuously.
module ledr_pattern_lut
    import ledr_pkg::*;
(
    input  ledr_idx_t   idx,
    output logic [9:0]  pat_cur,
    output logic [9:0]  pat_succ,
    output ledr_idx_t   idx_succ
);

    // Successor index and both candidate patterns for the current position.
    always_comb begin
        idx_succ = succ_of(idx);
        pat_cur  = pattern_of(idx);
        pat_succ = pattern_of(idx_succ);
    end

endmodule

// File: rtl/ledr_decoder.sv
// Receive-side monitor for the LEDR pattern bus: tracks legal order, flags and counts faults and loops.
// Latency: 1 cycle from an en=1 sample to registered outputs; en=0 holds state (non-sticky err clears).
// Backpressure: none; a sample is taken on every en=1 cycle. LEDR_DEC_STICKY_ERR_EN makes err sticky.
module ledr_decoder
    import ledr_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [9:0]       ledr,
    output ledr_idx_t        idx,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] loop_cnt
);

    dec_state_t       state_q, state_nxt;
    ledr_idx_t        idx_nxt;
    logic             locked_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] err_cnt_nxt;
    logic [CNT_W-1:0] loop_cnt_nxt;

    logic [9:0]       pat_cur;
    logic [9:0]       pat_succ;
    ledr_idx_t        idx_succ;

    ledr_pattern_lut u_lut (
        .idx      (idx),
        .pat_cur  (pat_cur),
        .pat_succ (pat_succ),
        .idx_succ (idx_succ)
    );

    // Next-state and next-output decode; the current pattern is checked before the successor
    // so that 10'h3FF at idx 10 or 16 is a hold, not an advance.
    always_comb begin
        state_nxt    = state_q;
        idx_nxt      = idx;
        locked_nxt   = locked;
`ifdef LEDR_DEC_STICKY_ERR_EN
        err_nxt      = err;
`else
        err_nxt      = 1'b0;
`endif
        err_cnt_nxt  = err_cnt;
        loop_cnt_nxt = loop_cnt;

        if (en) begin
            case (state_q)
                SEARCH, FAULT: begin
                    // Only the start of the ramp is a valid place to (re)acquire the sequence.
                    if (ledr == LEDR_0) begin
                        state_nxt  = TRACK;
                        idx_nxt    = '0;
                        locked_nxt = 1'b1;
                    end
                end
                TRACK: begin
                    if (ledr == pat_cur) begin
                        state_nxt = TRACK;
                    end else if (ledr == pat_succ) begin
                        idx_nxt = idx_succ;
                        if (idx == IDX_LAST && loop_cnt != '1) begin
                            loop_cnt_nxt = loop_cnt + 1'b1;
                        end
                    end else begin
                        // idx keeps the last good position for post-mortem inspection.
                        state_nxt  = FAULT;
                        locked_nxt = 1'b0;
                        err_nxt    = 1'b1;
                        if (err_cnt != '1) begin
                            err_cnt_nxt = err_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt  = SEARCH;
                    idx_nxt    = '0;
                    locked_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEARCH;
            idx      <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            loop_cnt <= '0;
        end else begin
            state_q  <= state_nxt;
            idx      <= idx_nxt;
            locked   <= locked_nxt;
            err      <= err_nxt;
            err_cnt  <= err_cnt_nxt;
            loop_cnt <= loop_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_ledr_decoder.sv
// Directed self-checking bench for ledr_decoder: ramp, loops, holds, faults, saturation, reset.
// Latency: checks outputs 1 ns after each clock edge following the sample.
// Backpressure: n/a; the bench drives en directly.
module tb_ledr_decoder;

`ifdef LEDR_DEC_STICKY_ERR_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       en;
    logic [9:0] ledr;
    logic [4:0] idx;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic [7:0] loop_cnt;

    int n_checks;
    int n_fail;

    logic [9:0] loop_pat [0:5];

    ledr_decoder #(.CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .ledr     (ledr),
        .idx      (idx),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt),
        .loop_cnt (loop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one input vector for one clock, then settle just after the edge.
    task automatic step(input logic [9:0] p, input logic e);
        ledr = p;
        en   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(10'h155, 1'b1);
        step(10'h155, 1'b1);
        n_checks++; if (idx !== 5'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", idx); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        n_checks++; if (loop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_loop_cnt: got %0d want 0", loop_cnt); end
        reset = 1'b0;
        step(10'h155, 1'b1);
        step(10'h3FF, 1'b1);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL search_locked: got %b want 0", locked); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL search_err: got %b want 0", err); end
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL search_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_ramp();
        logic [10:0] t;
        for (int n = 0; n <= 10; n++) begin
            t = (11'd1 << n) - 11'd1;
            step(t[9:0], 1'b1);
            n_checks++; if (idx !== 5'(n)) begin n_fail++; $display("FAIL ramp_idx[%0d]: got %0d want %0d", n, idx, n); end
            n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL ramp_locked[%0d]: got %b want 1", n, locked); end
            n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ramp_err[%0d]: got %b want 0", n, err); end
        end
    endtask

    task automatic test_loops();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 6; k++) begin
                step(loop_pat[k], 1'b1);
                n_checks++; if (idx !== 5'(11 + k)) begin n_fail++; $display("FAIL loop_idx[%0d,%0d]: got %0d want %0d", r, k, idx, 11 + k); end
                n_checks++; if (loop_cnt !== 8'(r)) begin n_fail++; $display("FAIL loop_cnt[%0d,%0d]: got %0d want %0d", r, k, loop_cnt, r); end
            end
        end
        n_checks++; if (locked !== 1'b1 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL loop_state: locked %b err_cnt %0d want 1/0", locked, err_cnt); end
    endtask

    task automatic test_hold();
        for (int k = 0; k < 3; k++) begin
            step(10'h3FF, 1'b1);
            n_checks++; if (idx !== 5'd16 || err !== 1'b0 || locked !== 1'b1) begin
                n_fail++; $display("FAIL hold16[%0d]: idx %0d err %b locked %b want 16/0/1", k, idx, err, locked);
            end
        end
        step(10'h3FF, 1'b0);
        step(10'h000, 1'b0);
        n_checks++; if (idx !== 5'd16 || locked !== 1'b1 || loop_cnt !== 8'd1 || err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL en_low_hold: idx %0d locked %b loop %0d errc %0d want 16/1/1/0", idx, locked, loop_cnt, err_cnt);
        end
    endtask

    task automatic test_fault();
        step(10'h2AA, 1'b1);
        step(10'h155, 1'b1);
        n_checks++; if (idx !== 5'd12) begin n_fail++; $display("FAIL pre_fault_idx: got %0d want 12", idx); end
        loop_cnt_chk: begin
            n_checks++; if (loop_cnt !== 8'd2) begin n_fail++; $display("FAIL pre_fault_loop_cnt: got %0d want 2", loop_cnt); end
        end
        step(10'h01F, 1'b1);
        n_checks++; if (locked !== 1'b0 || err !== 1'b1 || err_cnt !== 8'd1 || idx !== 5'd12) begin
            n_fail++; $display("FAIL fault_enter: locked %b err %b errc %0d idx %0d want 0/1/1/12", locked, err, err_cnt, idx);
        end
        step(10'h155, 1'b0);
        n_checks++; if (err !== STICKY) begin n_fail++; $display("FAIL err_after_pulse: got %b want %b", err, STICKY); end
        step(10'h155, 1'b1);
        n_checks++; if (err_cnt !== 8'd1 || locked !== 1'b0 || err !== STICKY) begin
            n_fail++; $display("FAIL fault_stay: errc %0d locked %b err %b want 1/0/%b", err_cnt, locked, err, STICKY);
        end
        step(10'h000, 1'b1);
        n_checks++; if (locked !== 1'b1 || idx !== 5'd0 || err_cnt !== 8'd1 || err !== STICKY) begin
            n_fail++; $display("FAIL resync: locked %b idx %0d errc %0d err %b want 1/0/1/%b", locked, idx, err_cnt, err, STICKY);
        end
        // An unexpected LEDR_0 mid-ramp is illegal, then resyncs on the next LEDR_0.
        step(10'h001, 1'b1);
        step(10'h000, 1'b1);
        n_checks++; if (locked !== 1'b0 || err_cnt !== 8'd2 || idx !== 5'd1 || err !== 1'b1) begin
            n_fail++; $display("FAIL zero_midramp: locked %b errc %0d idx %0d err %b want 0/2/1/1", locked, err_cnt, idx, err);
        end
        step(10'h000, 1'b1);
        n_checks++; if (locked !== 1'b1 || idx !== 5'd0 || err_cnt !== 8'd2) begin
            n_fail++; $display("FAIL zero_resync: locked %b idx %0d errc %0d want 1/0/2", locked, idx, err_cnt);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        exp_cnt = 2;
        for (int i = 0; i < 257; i++) begin
            step(10'h001, 1'b1);
            step(10'h3E0, 1'b1);
            exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
            n_checks++; if (err_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL sat_err_cnt[%0d]: got %0d want %0d", i, err_cnt, exp_cnt); end
            step(10'h000, 1'b1);
        end
        n_checks++; if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_final: got %0h want ff", err_cnt); end
        n_checks++; if (err !== STICKY || locked !== 1'b1) begin n_fail++; $display("FAIL sat_resync: err %b locked %b want %b/1", err, locked, STICKY); end
        // Reset mid-ramp with en high must override the sample.
        step(10'h001, 1'b1);
        step(10'h003, 1'b1);
        n_checks++; if (idx !== 5'd2) begin n_fail++; $display("FAIL pre_reset_idx: got %0d want 2", idx); end
        reset = 1'b1;
        step(10'h007, 1'b1);
        reset = 1'b0;
        n_checks++; if (idx !== 5'd0 || locked !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0 || loop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL midloop_reset: idx %0d locked %b err %b errc %0d loop %0d want all 0", idx, locked, err, err_cnt, loop_cnt);
        end
        step(10'h001, 1'b1);
        n_checks++; if (locked !== 1'b0 || idx !== 5'd0) begin n_fail++; $display("FAIL post_reset_search: locked %b idx %0d want 0/0", locked, idx); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        en       = 1'b0;
        ledr     = 10'h000;
        loop_pat[0] = 10'h2AA;
        loop_pat[1] = 10'h155;
        loop_pat[2] = 10'h3E0;
        loop_pat[3] = 10'h01F;
        loop_pat[4] = 10'h201;
        loop_pat[5] = 10'h3FF;
        test_reset();
        test_ramp();
        test_loops();
        test_hold();
        test_fault();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
